// File: rtl/button_press_classifier.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : button_press_classifier
// Purpose : Classifies debounced button presses as short, long or double and
//           emits one-cycle event pulses, a held-long status and an event count.
// Revision: 1.0 - initial release
// ============================================================================
module button_press_classifier #(
    parameter int LONG_CYCLES       = 1000,
    parameter int DOUBLE_GAP_CYCLES = 300,
    parameter int CNT_WIDTH         = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       debouncedInput,
    output logic       shortPress,
    output logic       longPress,
    output logic       doublePress,
    output logic       longHeld,
    output logic [7:0] pressCount
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRESS1    = 3'd1,
        ST_GAP       = 3'd2,
        ST_PRESS2    = 3'd3,
        ST_LONG_HOLD = 3'd4
    } state_t;

    localparam logic [CNT_WIDTH-1:0] c_cnt_one   = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] c_cnt_max   = '1;
    localparam logic [CNT_WIDTH-1:0] c_long_last = CNT_WIDTH'(LONG_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] c_gap_last  = CNT_WIDTH'(DOUBLE_GAP_CYCLES - 1);

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 short_press_q, short_press_d;
    logic                 long_press_q, long_press_d;
    logic                 double_press_q, double_press_d;
    logic                 long_held_q, long_held_d;
    logic [7:0]           press_count_q, press_count_d;
    logic [CNT_WIDTH-1:0] w_cnt_inc;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        short_press_d  = 1'b0;
        long_press_d   = 1'b0;
        double_press_d = 1'b0;
        w_cnt_inc      = (cnt_q == c_cnt_max) ? cnt_q : cnt_q + c_cnt_one;

        // cnt holds the number of samples already seen in the current phase,
        // so comparing against N-1 fires on the N-th sample.
        case (state_q)
            ST_IDLE: begin
                if (debouncedInput) begin
                    state_d = ST_PRESS1;
                    cnt_d   = c_cnt_one;
                end
            end
            ST_PRESS1: begin
                if (debouncedInput) begin
                    if (cnt_q == c_long_last) begin
                        state_d      = ST_LONG_HOLD;
                        long_press_d = 1'b1;
                    end else begin
                        cnt_d = w_cnt_inc;
                    end
                end else if (DOUBLE_GAP_CYCLES == 1) begin
                    state_d       = ST_IDLE;
                    cnt_d         = '0;
                    short_press_d = 1'b1;
                end else begin
                    state_d = ST_GAP;
                    cnt_d   = c_cnt_one;
                end
            end
            ST_GAP: begin
                if (debouncedInput) begin
                    state_d = ST_PRESS2;
                    cnt_d   = c_cnt_one;
                end else if (cnt_q == c_gap_last) begin
                    state_d       = ST_IDLE;
                    cnt_d         = '0;
                    short_press_d = 1'b1;
                end else begin
                    cnt_d = w_cnt_inc;
                end
            end
            ST_PRESS2: begin
                if (!debouncedInput) begin
                    state_d        = ST_IDLE;
                    cnt_d          = '0;
                    double_press_d = 1'b1;
                end else if (cnt_q == c_long_last) begin
                    state_d        = ST_LONG_HOLD;
                    double_press_d = 1'b1;
                end else begin
                    cnt_d = w_cnt_inc;
                end
            end
            ST_LONG_HOLD: begin
                if (!debouncedInput) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        long_held_d   = (state_d == ST_LONG_HOLD);
        press_count_d = press_count_q;
        if (short_press_d || long_press_d || double_press_d) begin
            press_count_d = press_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            short_press_q  <= 1'b0;
            long_press_q   <= 1'b0;
            double_press_q <= 1'b0;
            long_held_q    <= 1'b0;
            press_count_q  <= 8'd0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            short_press_q  <= short_press_d;
            long_press_q   <= long_press_d;
            double_press_q <= double_press_d;
            long_held_q    <= long_held_d;
            press_count_q  <= press_count_d;
        end
    end

    assign shortPress  = short_press_q;
    assign longPress   = long_press_q;
    assign doublePress = double_press_q;
    assign longHeld    = long_held_q;
    assign pressCount  = press_count_q;

endmodule
`default_nettype wire

// File: tb/tb_button_press_classifier.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_button_press_classifier
// Purpose : Scoreboard bench for button_press_classifier (LONG=8, GAP=4).
// Revision: 1.0 - initial release
// ============================================================================
module tb_button_press_classifier;

    localparam int P_LONG = 8;
    localparam int P_GAP  = 4;

    localparam int K_NONE   = 0;
    localparam int K_SHORT  = 1;
    localparam int K_LONG   = 2;
    localparam int K_DOUBLE = 3;

    typedef struct {
        int         kind;
        int         at_edge;
        logic [7:0] count;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       debouncedInput = 1'b0;
    logic       shortPress, longPress, doublePress, longHeld;
    logic [7:0] pressCount;

    exp_t       exp_q[$];
    logic [7:0] exp_count = 8'd0;
    logic       exp_held  = 1'b0;
    int         edge_cnt  = 0;
    bit         mon_en    = 1'b0;
    int         checks    = 0;
    int         errors    = 0;

    button_press_classifier #(
        .LONG_CYCLES      (P_LONG),
        .DOUBLE_GAP_CYCLES(P_GAP),
        .CNT_WIDTH        (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .debouncedInput(debouncedInput),
        .shortPress    (shortPress),
        .longPress     (longPress),
        .doublePress   (doublePress),
        .longHeld      (longHeld),
        .pressCount    (pressCount)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Drive one input sample; if kind names a pulse, it must appear right after this edge.
    task automatic step(input logic v, input int kind, input logic held);
        exp_t e;
        debouncedInput = v;
        if (kind != K_NONE) begin
            e.kind    = kind;
            e.at_edge = edge_cnt + 1;
            e.count   = exp_count + 8'd1;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        if (reset) begin
            exp_count = 8'd0;
            exp_held  = 1'b0;
        end else begin
            if (kind != K_NONE) exp_count = exp_count + 8'd1;
            exp_held = held;
        end
    endtask

    task automatic steps(input logic v, input int n, input logic held);
        for (int i = 0; i < n; i++) step(v, K_NONE, held);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a pulse.
    always @(negedge clk) begin
        if (mon_en) begin
            int   n_pulse;
            int   got_kind;
            exp_t e;
            n_pulse  = int'(shortPress) + int'(longPress) + int'(doublePress);
            got_kind = shortPress ? K_SHORT : (longPress ? K_LONG : (doublePress ? K_DOUBLE : K_NONE));
            if (n_pulse != 0) begin
                checks++;
                if (n_pulse > 1) begin
                    errors++;
                    $display("FAIL multi_pulse edge=%0d: short=%b long=%b double=%b, required at most one",
                             edge_cnt, shortPress, longPress, doublePress);
                end else if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pulse edge=%0d: kind=%0d, required no pulse", edge_cnt, got_kind);
                end else begin
                    e = exp_q.pop_front();
                    if (e.kind != got_kind || e.at_edge != edge_cnt || e.count != pressCount) begin
                        errors++;
                        $display("FAIL pulse: got kind=%0d edge=%0d count=%0d, required kind=%0d edge=%0d count=%0d",
                                 got_kind, edge_cnt, pressCount, e.kind, e.at_edge, e.count);
                    end
                end
            end else if (exp_q.size() != 0 && exp_q[0].at_edge <= edge_cnt) begin
                checks++;
                errors++;
                e = exp_q.pop_front();
                $display("FAIL missing_pulse edge=%0d: no pulse, required kind=%0d count=%0d",
                         edge_cnt, e.kind, e.count);
            end
            checks++;
            if (longHeld !== exp_held) begin
                errors++;
                $display("FAIL longHeld edge=%0d: got %b, required %b", edge_cnt, longHeld, exp_held);
            end
            checks++;
            if (pressCount !== exp_count) begin
                errors++;
                $display("FAIL pressCount edge=%0d: got %0d, required %0d", edge_cnt, pressCount, exp_count);
            end
        end
    end

    initial begin
        // Reset held 10 cycles while the input toggles.
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(logic'(i % 2 == 0), K_NONE, 1'b0);
            mon_en = 1'b1;
        end
        reset = 1'b0;
        steps(1'b0, 3, 1'b0);

        // Short press: 3 high, pulse after the 4th low.
        steps(1'b1, 3, 1'b0);
        steps(1'b0, 3, 1'b0);
        step(1'b0, K_SHORT, 1'b0);
        steps(1'b0, 3, 1'b0);

        // Long press: 12 high, longPress after the 8th.
        steps(1'b1, P_LONG - 1, 1'b0);
        step(1'b1, K_LONG, 1'b1);
        steps(1'b1, 4, 1'b1);
        steps(1'b0, 6, 1'b0);

        // Double press with short second press.
        steps(1'b1, 3, 1'b0);
        steps(1'b0, 2, 1'b0);
        steps(1'b1, 2, 1'b0);
        step(1'b0, K_DOUBLE, 1'b0);
        steps(1'b0, 6, 1'b0);

        // Double press with long second press: no longPress.
        steps(1'b1, 3, 1'b0);
        steps(1'b0, 3, 1'b0);
        steps(1'b1, P_LONG - 1, 1'b0);
        step(1'b1, K_DOUBLE, 1'b1);
        steps(1'b1, 2, 1'b1);
        steps(1'b0, 6, 1'b0);

        // Press of LONG-1 samples is still short.
        steps(1'b1, P_LONG - 1, 1'b0);
        steps(1'b0, 3, 1'b0);
        step(1'b0, K_SHORT, 1'b0);

        // Gap of exactly GAP lows resolves short; next press starts fresh.
        steps(1'b1, 2, 1'b0);
        steps(1'b0, 3, 1'b0);
        step(1'b0, K_SHORT, 1'b0);
        steps(1'b1, 2, 1'b0);
        steps(1'b0, 3, 1'b0);
        step(1'b0, K_SHORT, 1'b0);

        // Third press does not fold into the double.
        step(1'b1, K_NONE, 1'b0);
        step(1'b0, K_NONE, 1'b0);
        step(1'b1, K_NONE, 1'b0);
        step(1'b0, K_DOUBLE, 1'b0);
        step(1'b1, K_NONE, 1'b0);
        steps(1'b0, 3, 1'b0);
        step(1'b0, K_SHORT, 1'b0);
        steps(1'b0, 2, 1'b0);

        // Reset during GAP aborts the pending short press.
        steps(1'b1, 2, 1'b0);
        steps(1'b0, 2, 1'b0);
        reset = 1'b1;
        step(1'b0, K_NONE, 1'b0);
        reset = 1'b0;
        steps(1'b0, 8, 1'b0);
        step(1'b1, K_NONE, 1'b0);
        steps(1'b0, 3, 1'b0);
        step(1'b0, K_SHORT, 1'b0);

        // Input already high when reset releases counts as a new press.
        reset = 1'b1;
        step(1'b1, K_NONE, 1'b0);
        reset = 1'b0;
        steps(1'b1, P_LONG - 1, 1'b0);
        step(1'b1, K_LONG, 1'b1);
        step(1'b0, K_NONE, 1'b0);

        // 256 short presses wrap pressCount to 0.
        reset = 1'b1;
        step(1'b0, K_NONE, 1'b0);
        reset = 1'b0;
        for (int n = 0; n < 256; n++) begin
            step(1'b1, K_NONE, 1'b0);
            steps(1'b0, 3, 1'b0);
            step(1'b0, K_SHORT, 1'b0);
        end
        checks++;
        if (pressCount !== 8'd0) begin
            errors++;
            $display("FAIL wrap: pressCount got %0d, required 0", pressCount);
        end
        steps(1'b0, 3, 1'b0);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d pulses outstanding, required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
